// File: rtl/ahb_gpio_initiator.sv
// ahb_gpio_initiator
// AHB-Lite initiator that converts a valid/ready command stream into
// single-beat NONSEQ transfers for the AHB GPIO peripheral. The design keeps
// two registered stages: address phase (A) and data phase (D). It returns one
// response pulse per completed transfer.
//
// Optional build macro: AHB_GPIO_INITIATOR_PARITY_EN
//   defined   -> PARITYERR is sampled at data-phase completion into rsp_perr
//   undefined -> PARITYERR is ignored and rsp_perr is held at 0
module ahb_gpio_initiator #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [DATA_W-1:0] HWDATA,
    output logic              HSEL,
    output logic              HREADY,
    input  logic              HREADYOUT,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              PARITYERR,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_perr,
    output logic [CNT_W-1:0]  xfer_count
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    // Address-phase stage
    logic              a_valid_reg, a_valid_next;
    logic              a_write_reg, a_write_next;
    logic [ADDR_W-1:0] a_addr_reg,  a_addr_next;
    logic [DATA_W-1:0] a_wdata_reg, a_wdata_next;

    // Data-phase stage
    logic              d_valid_reg, d_valid_next;
    logic              d_write_reg, d_write_next;
    logic [DATA_W-1:0] d_wdata_reg, d_wdata_next;

    // Response and counter
    logic              rsp_valid_reg,  rsp_valid_next;
    logic              rsp_write_reg,  rsp_write_next;
    logic [DATA_W-1:0] rsp_rdata_reg,  rsp_rdata_next;
    logic              rsp_perr_reg,   rsp_perr_next;
    logic [CNT_W-1:0]  xfer_count_reg, xfer_count_next;

    logic              accept;
    logic              complete;
    logic [DATA_W-1:0] rdata_masked;
    logic              perr_sample;

    // A slot can take a new command when it is empty or draining this edge.
    assign cmd_ready = !a_valid_reg | HREADYOUT;
    assign accept    = cmd_valid & cmd_ready;
    assign complete  = HREADYOUT & d_valid_reg;

    // Writes report zero read data; force each bit low for a write in D.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_rdata_mask
        assign rdata_masked[gi] = HRDATA[gi] & ~d_write_reg;
    end

`ifdef AHB_GPIO_INITIATOR_PARITY_EN
    assign perr_sample = PARITYERR;
`else
    // Parity input exists on the port list in both builds but is not used here.
    logic unused_parityerr;
    assign unused_parityerr = PARITYERR;
    assign perr_sample      = 1'b0;
`endif

    // Bus outputs come straight from the stage registers.
    assign HTRANS     = a_valid_reg ? TRANS_NONSEQ : TRANS_IDLE;
    assign HSEL       = a_valid_reg;
    assign HADDR      = a_addr_reg;
    assign HWRITE     = a_write_reg;
    assign HWDATA     = d_wdata_reg;
    assign HREADY     = HREADYOUT;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_write  = rsp_write_reg;
    assign rsp_rdata  = rsp_rdata_reg;
    assign rsp_perr   = rsp_perr_reg;
    assign xfer_count = xfer_count_reg;

    // Address stage: load on accept, otherwise empty out once the bus advances.
    always_comb begin
        a_valid_next = a_valid_reg;
        a_write_next = a_write_reg;
        a_addr_next  = a_addr_reg;
        a_wdata_next = a_wdata_reg;
        if (accept) begin
            a_valid_next = 1'b1;
            a_write_next = cmd_write;
            a_addr_next  = cmd_addr;
            a_wdata_next = cmd_wdata;
        end else if (HREADYOUT) begin
            a_valid_next = 1'b0;
        end
    end

    // Data stage: follows the address stage whenever the slave is ready.
    always_comb begin
        d_valid_next = d_valid_reg;
        d_write_next = d_write_reg;
        d_wdata_next = d_wdata_reg;
        if (HREADYOUT) begin
            d_valid_next = a_valid_reg;
            d_write_next = a_write_reg;
            d_wdata_next = a_wdata_reg;
        end
    end

    // Response: a one-cycle pulse after each data phase completes. The payload
    // holds until the next completion.
    always_comb begin
        rsp_valid_next  = 1'b0;
        rsp_write_next  = rsp_write_reg;
        rsp_rdata_next  = rsp_rdata_reg;
        rsp_perr_next   = rsp_perr_reg;
        xfer_count_next = xfer_count_reg;
        if (complete) begin
            rsp_valid_next  = 1'b1;
            rsp_write_next  = d_write_reg;
            rsp_rdata_next  = rdata_masked;
            rsp_perr_next   = perr_sample;
            xfer_count_next = xfer_count_reg + CNT_W'(1);
        end
    end

    // State registers: reset drops both stages and any in-flight response.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_reg    <= 1'b0;
            a_write_reg    <= 1'b0;
            a_addr_reg     <= '0;
            a_wdata_reg    <= '0;
            d_valid_reg    <= 1'b0;
            d_write_reg    <= 1'b0;
            d_wdata_reg    <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_write_reg  <= 1'b0;
            rsp_rdata_reg  <= '0;
            rsp_perr_reg   <= 1'b0;
            xfer_count_reg <= '0;
        end else begin
            a_valid_reg    <= a_valid_next;
            a_write_reg    <= a_write_next;
            a_addr_reg     <= a_addr_next;
            a_wdata_reg    <= a_wdata_next;
            d_valid_reg    <= d_valid_next;
            d_write_reg    <= d_write_next;
            d_wdata_reg    <= d_wdata_next;
            rsp_valid_reg  <= rsp_valid_next;
            rsp_write_reg  <= rsp_write_next;
            rsp_rdata_reg  <= rsp_rdata_next;
            rsp_perr_reg   <= rsp_perr_next;
            xfer_count_reg <= xfer_count_next;
        end
    end

endmodule

// File: doc/ahb_gpio_initiator.md
Name: ahb_gpio_initiator

Overview:
- AHB-Lite initiator that turns a simple valid/ready command stream into pipelined single-beat NONSEQ transfers toward the AHB GPIO peripheral.
- Lets on-chip logic drive the GPIO block directly instead of through a processor.
- Sits between a command source (sequencer or bridge) and the GPIO slave's HADDR/HTRANS/HWRITE/HWDATA/HSEL/HREADY inputs.
- Returns one response per transfer.

Parameters:
- ADDR_W, 32, address width (HADDR, cmd_addr)
- DATA_W, 32, data width (HWDATA, HRDATA, cmd_wdata, rsp_rdata)
- CNT_W, 16, width of the completed-transfer counter

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted on edge where cmd_valid&cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data
- HADDR  out  ADDR_W  AHB address
- HTRANS  out  2  2'b00 IDLE / 2'b10 NONSEQ only
- HWRITE  out  1  AHB direction
- HWDATA  out  DATA_W  AHB write data (data phase)
- HSEL  out  1  slave select
- HREADY  out  1  forwarded HREADYOUT (single-slave system)
- HREADYOUT  in  1  slave ready
- HRDATA  in  DATA_W  slave read data
- PARITYERR  in  1  slave parity error (used only with optional feature)
- rsp_valid  out  1  one-cycle response pulse
- rsp_write  out  1  direction of completed transfer
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_perr  out  1  parity error for completed transfer
- xfer_count  out  CNT_W  completed transfers, wraps

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high.
- Reset values: HTRANS=00, HSEL=0, HWRITE=0, HADDR=0, HWDATA=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_perr=0, xfer_count=0. Both pipeline stages empty.
- Two registered stages:
  - A (address phase): a_valid, a_write, a_addr, a_wdata.
  - D (data phase): d_valid, d_write, d_wdata.
- Outputs:
  - HTRANS = a_valid ? 10 : 00
  - HSEL = a_valid
  - HADDR = a_addr, HWRITE = a_write
  - HWDATA = d_wdata
  - HREADY = HREADYOUT (combinational)
- cmd_ready = !a_valid | HREADYOUT (combinational). On accept, A loads cmd_* and a_valid=1; otherwise A clears to empty when HREADYOUT=1.
- Edge with HREADYOUT=1:
  - D <= A (including valid).
  - If d_valid was set, the data phase completes: next cycle rsp_valid=1, rsp_write=d_write, rsp_rdata = d_write ? 0 : HRDATA sampled at that edge, xfer_count+1.
- Edge with HREADYOUT=0:
  - A and D hold; HADDR/HTRANS/HWRITE/HWDATA stable.
  - If a_valid=0, a new command may still be accepted (IDLE to NONSEQ during a wait is legal) and is then held.
- rsp_valid is otherwise 0; there is no response back-pressure.
- Latency with no waits: command accepted at edge N → NONSEQ visible cycle N+1 → HWDATA/data phase cycle N+2 → rsp_valid cycle N+3. Back-to-back commands sustain one transfer per cycle.
- xfer_count wraps from 2^CNT_W-1 to 0.
- Reset asserted mid-transfer: both stages cleared at that edge and HTRANS=00 the next cycle. The in-flight response is dropped and xfer_count=0. cmd_ready is driven but ignored while rst=1, and nothing is accepted.

Optional Feature:
- Macro AHB_GPIO_INITIATOR_PARITY_EN.
- Defined: PARITYERR is sampled at the data-phase completion edge, and rsp_perr = that sample, valid alongside rsp_valid.
- Undefined: PARITYERR is ignored and rsp_perr is constant 0. Port list is identical in both builds.

Test Plan:
- Reset then write 0x5300_0004/0x0001_ABCD, HREADYOUT=1 → N+1 HTRANS=10, HADDR=0x5300_0004, HWRITE=1, HSEL=1; N+2 HWDATA=0x0001_ABCD, HTRANS=00; N+3 rsp_valid=1, rsp_write=1, xfer_count=1.
- Read 0x5300_0000, slave holds HREADYOUT=0 two data-phase cycles then returns HRDATA=0x0000_1234 → HWDATA/addr stable during waits; rsp_valid one cycle after HREADYOUT rises, rsp_rdata=0x0000_1234.
- Write then read issued back-to-back, zero waits → HTRANS=10 on two consecutive cycles, two consecutive rsp_valid pulses (write, read), xfer_count +2.
- Read outstanding, second command valid while HREADYOUT=0 and a_valid=1 → cmd_ready=0, second HADDR held stable until HREADYOUT=1.
- rst=1 during a waited data phase → next cycle HTRANS=00, HSEL=0, no rsp_valid for the dropped transfer, xfer_count=0.
- Macro defined: read completes with PARITYERR=1 → rsp_perr=1 with rsp_valid. Macro undefined: same stimulus → rsp_perr=0.
